// File: rtl/frame_receiver.sv
// -----------------------------------------------------------------------------
// frame_receiver
//
// Serial receiver for 14-bit frames: one start bit (0), twelve data bits sent
// LSB first, and one stop bit (1). The line is oversampled at CLKS_PER_BIT clk
// cycles per bit. Each bit is sampled at its centre: the start bit is
// re-checked half a bit after the falling edge, and every later bit is sampled
// one full bit period after the previous sample.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (4..1023)
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   rx_in      : asynchronous serial line, idle high
//   data_word  : last correctly framed word, held until the next good word
//   word_valid : one-cycle pulse, data_word has just been updated
//   frame_err  : one-cycle pulse, the stop bit was sampled low
//   busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module frame_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  output logic [11:0] data_word,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_reg;
  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       idx_reg;
  logic [11:0]      shift_reg;
  logic             rx_s;

  // Second synchronizer stage is the only view of the line the FSM uses.
  assign rx_s = sync_reg[1];
  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      sync_reg   <= 2'b11;   // idle-high so reset never looks like a start bit
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      data_word  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], rx_in};
      word_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end

        START: begin
          if (cnt_reg == CNT_MID) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            // A line that is high again at mid start bit was only a glitch.
            state_reg <= rx_s ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg            <= '0;
            shift_reg[idx_reg] <= rx_s;
            if (idx_reg == 4'd11) begin
              idx_reg   <= '0;
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              data_word  <= shift_reg;
              word_valid <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state_reg <= WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // Hold off until the line recovers so a stuck-low line cannot
        // be mistaken for a stream of start bits.
        WAIT_HIGH: begin
          if (rx_s) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_frame_receiver
//
// Drives serial frames onto two receivers (CLKS_PER_BIT=4 and the default 16)
// and compares what they report against expectations derived from the frame
// format: words seen per good frame, error pulses per bad stop bit, latency
// of 13.5 bit periods plus 3 clk, and spacing of 14 bit periods for
// back-to-back frames.
// -----------------------------------------------------------------------------
module tb_frame_receiver;

  localparam int C4  = 4;
  localparam int C16 = 16;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        rx4 = 1'b1;
  logic        rx16 = 1'b1;
  logic [11:0] dw4, dw16;
  logic        wv4, fe4, bz4, wv16, fe16, bz16;

  frame_receiver #(.CLKS_PER_BIT(C4)) dut (
    .clk(clk), .reset(srst), .rx_in(rx4),
    .data_word(dw4), .word_valid(wv4), .frame_err(fe4), .busy(bz4)
  );

  frame_receiver dut16 (
    .clk(clk), .reset(srst), .rx_in(rx16),
    .data_word(dw16), .word_valid(wv16), .frame_err(fe16), .busy(bz16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int fails = 0;

  // Monitor state, sampled on the falling edge.
  logic [11:0] got_q[$];
  int          got_t[$];
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          dw_glitch = 0;
  int          busy_seen = 0;
  logic [11:0] dw_prev = 12'h000;
  int          words16 = 0;
  int          errs16 = 0;
  logic [11:0] last16 = 12'h000;
  logic [11:0] model_last = 12'h000;

  always @(negedge clk) begin
    if (wv4) begin
      got_q.push_back(dw4);
      got_t.push_back(cyc);
      $display("[TB] rx word 0x%03h at cycle %0d", dw4, cyc);
    end
    if (fe4) begin
      err_cnt++;
      $display("[TB] rx frame error at cycle %0d", cyc);
    end
    if (wv4 && fe4) both_cnt++;
    if (!srst && !wv4 && (dw4 !== dw_prev)) dw_glitch++;
    dw_prev = dw4;
    if (bz4) busy_seen++;
    if (wv16) begin
      words16++;
      last16 = dw16;
      $display("[TB] rx16 word 0x%03h at cycle %0d", dw16, cyc);
    end
    if (fe16) errs16++;
  end

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    err_cnt   = 0;
    both_cnt  = 0;
    dw_glitch = 0;
    busy_seen = 0;
  endtask

  task automatic drive_bit(input bit sel, input logic b, input int c);
    if (sel) rx16 = b; else rx4 = b;
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Line is left at the stop-bit level afterwards.
  task automatic send_frame(input bit sel, input int c, input logic [11:0] d,
                            input logic stop_b, output int t_start);
    t_start = cyc;
    drive_bit(sel, 1'b0, c);
    for (int i = 0; i < 12; i++) drive_bit(sel, d[i], c);
    drive_bit(sel, stop_b, c);
    $display("[TB] sent frame data=0x%03h stop=%0b", d, stop_b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    idle(3);
    tests_run++; if (dw4 !== 12'h000) begin fails++; $display("FAIL reset_data_word got=0x%03h exp=0x000", dw4); end
    tests_run++; if (wv4 !== 1'b0) begin fails++; $display("FAIL reset_word_valid got=%b exp=0", wv4); end
    tests_run++; if (fe4 !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", fe4); end
    tests_run++; if (bz4 !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bz4); end
    tests_run++; if (dw16 !== 12'h000) begin fails++; $display("FAIL reset_data_word16 got=0x%03h exp=0x000", dw16); end
    srst = 1'b0;
    idle(4);
  endtask

  task automatic test_single();
    int t0;
    int exp_lat;
    clear_mon();
    send_frame(1'b0, C4, 12'h0C0, 1'b1, t0);
    model_last = 12'h0C0;
    idle(2 * C4);
    exp_lat = (27 * C4) / 2 + 3;
    tests_run++; if (got_q.size() !== 1) begin fails++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    tests_run++; if (((got_q.size() > 0) ? got_q[0] : 12'hxxx) !== 12'h0C0) begin fails++; $display("FAIL single_data got=0x%03h exp=0x0C0", dw4); end
    tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL single_err got=%0d exp=0", err_cnt); end
    tests_run++; if (bz4 !== 1'b0) begin fails++; $display("FAIL single_busy got=%b exp=0", bz4); end
    tests_run++; if (((got_t.size() > 0) ? got_t[0] - t0 : -1) !== exp_lat) begin fails++; $display("FAIL single_latency got=%0d exp=%0d", (got_t.size() > 0) ? got_t[0] - t0 : -1, exp_lat); end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    clear_mon();
    send_frame(1'b0, C4, 12'h0C0, 1'b1, t0);
    send_frame(1'b0, C4, 12'h030, 1'b1, t1);
    model_last = 12'h030;
    idle(2 * C4);
    tests_run++; if (got_q.size() !== 2) begin fails++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    tests_run++; if (((got_q.size() > 0) ? got_q[0] : 12'hxxx) !== 12'h0C0) begin fails++; $display("FAIL b2b_first got=0x%03h exp=0x0C0", (got_q.size() > 0) ? got_q[0] : 12'hxxx); end
    tests_run++; if (((got_q.size() > 1) ? got_q[1] : 12'hxxx) !== 12'h030) begin fails++; $display("FAIL b2b_second got=0x%03h exp=0x030", (got_q.size() > 1) ? got_q[1] : 12'hxxx); end
    tests_run++; if (((got_t.size() > 1) ? got_t[1] - got_t[0] : -1) !== 14 * C4) begin fails++; $display("FAIL b2b_spacing got=%0d exp=%0d", (got_t.size() > 1) ? got_t[1] - got_t[0] : -1, 14 * C4); end
    tests_run++; if (dw4 !== 12'h030) begin fails++; $display("FAIL b2b_hold got=0x%03h exp=0x030", dw4); end
  endtask

  task automatic test_frame_err();
    int t0;
    logic [11:0] d;
    clear_mon();
    send_frame(1'b0, C4, 12'hFFF, 1'b0, t0);
    idle(5 * C4);                        // line stays low
    tests_run++; if (err_cnt !== 1) begin fails++; $display("FAIL ferr_count got=%0d exp=1", err_cnt); end
    tests_run++; if (got_q.size() !== 0) begin fails++; $display("FAIL ferr_no_word got=%0d exp=0", got_q.size()); end
    tests_run++; if (dw4 !== model_last) begin fails++; $display("FAIL ferr_data_kept got=0x%03h exp=0x%03h", dw4, model_last); end
    tests_run++; if (bz4 !== 1'b1) begin fails++; $display("FAIL ferr_waiting_busy got=%b exp=1", bz4); end
    rx4 = 1'b1;
    idle(2 * C4);
    tests_run++; if (bz4 !== 1'b0) begin fails++; $display("FAIL ferr_recover_busy got=%b exp=0", bz4); end
    tests_run++; if (err_cnt !== 1) begin fails++; $display("FAIL ferr_single_pulse got=%0d exp=1", err_cnt); end
    d = 12'($urandom);
    send_frame(1'b0, C4, d, 1'b1, t0);
    model_last = d;
    idle(2 * C4);
    tests_run++; if (((got_q.size() > 0) ? got_q[0] : 12'hxxx) !== d) begin fails++; $display("FAIL ferr_next_frame got=0x%03h exp=0x%03h", dw4, d); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx4 = 1'b0;
    idle(1);
    rx4 = 1'b1;
    idle(4 * C4);
    tests_run++; if (busy_seen == 0) begin fails++; $display("FAIL glitch_seen got=%0d exp>0", busy_seen); end
    tests_run++; if (bz4 !== 1'b0) begin fails++; $display("FAIL glitch_busy got=%b exp=0", bz4); end
    tests_run++; if (got_q.size() !== 0) begin fails++; $display("FAIL glitch_word got=%0d exp=0", got_q.size()); end
    tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL glitch_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [11:0] d;
    clear_mon();
    d = 12'($urandom);
    drive_bit(1'b0, 1'b0, C4);
    for (int i = 0; i < 6; i++) drive_bit(1'b0, d[i], C4);
    rx4 = d[6];
    idle(2);
    srst = 1'b1;
    rx4  = 1'b1;
    idle(3);
    srst = 1'b0;
    model_last = 12'h000;
    idle(16 * C4);
    tests_run++; if (got_q.size() !== 0) begin fails++; $display("FAIL rstmid_word got=%0d exp=0", got_q.size()); end
    tests_run++; if (err_cnt !== 0) begin fails++; $display("FAIL rstmid_err got=%0d exp=0", err_cnt); end
    tests_run++; if (dw4 !== 12'h000) begin fails++; $display("FAIL rstmid_data got=0x%03h exp=0x000", dw4); end
    tests_run++; if (bz4 !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", bz4); end
    send_frame(1'b0, C4, 12'hA5A, 1'b1, t0);
    model_last = 12'hA5A;
    idle(2 * C4);
    tests_run++; if (((got_q.size() > 0) ? got_q[0] : 12'hxxx) !== 12'hA5A) begin fails++; $display("FAIL rstmid_next got=0x%03h exp=0xA5A", dw4); end
  endtask

  task automatic test_random();
    logic [11:0] exp_q[$];
    int          exp_err;
    int          t0, gap;
    logic [11:0] d;
    bit          bad;
    clear_mon();
    exp_err = 0;
    for (int n = 0; n < 12; n++) begin
      d   = 12'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      gap = bad ? $urandom_range(1, 2) : $urandom_range(0, 2);
      send_frame(1'b0, C4, d, bad ? 1'b0 : 1'b1, t0);
      if (bad) exp_err++;
      else begin exp_q.push_back(d); model_last = d; end
      if (gap > 0) drive_bit(1'b0, 1'b1, gap * C4);
    end
    idle(2 * C4);
    tests_run++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++;
      if (((i < got_q.size()) ? got_q[i] : 12'hxxx) !== exp_q[i]) begin
        fails++; $display("FAIL rand_word%0d got=0x%03h exp=0x%03h", i, (i < got_q.size()) ? got_q[i] : 12'hxxx, exp_q[i]);
      end
    end
    tests_run++; if (err_cnt !== exp_err) begin fails++; $display("FAIL rand_errs got=%0d exp=%0d", err_cnt, exp_err); end
    tests_run++; if (both_cnt !== 0) begin fails++; $display("FAIL rand_exclusive got=%0d exp=0", both_cnt); end
    tests_run++; if (dw_glitch !== 0) begin fails++; $display("FAIL rand_data_stable got=%0d exp=0", dw_glitch); end
    tests_run++; if (dw4 !== model_last) begin fails++; $display("FAIL rand_last got=0x%03h exp=0x%03h", dw4, model_last); end
  endtask

  task automatic test_default_param();
    int t0;
    int w0;
    w0 = words16;
    send_frame(1'b1, C16, 12'h001, 1'b1, t0);
    idle(2 * C16);
    tests_run++; if (words16 - w0 !== 1) begin fails++; $display("FAIL p16_count got=%0d exp=1", words16 - w0); end
    tests_run++; if (last16 !== 12'h001) begin fails++; $display("FAIL p16_data got=0x%03h exp=0x001", last16); end
    tests_run++; if (dw16 !== 12'h001) begin fails++; $display("FAIL p16_hold got=0x%03h exp=0x001", dw16); end
    tests_run++; if (errs16 !== 0) begin fails++; $display("FAIL p16_err got=%0d exp=0", errs16); end
    tests_run++; if (bz16 !== 1'b0) begin fails++; $display("FAIL p16_busy got=%b exp=0", bz16); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_random();
    test_default_param();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
